avalon_onchip_memory_dp: RTL



---
 rtl/avalon_onchip_memory_dp.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// avalon_onchip_memory_dp
//
// True-dual-port on-chip RAM with two independent Avalon-MM slave ports
// (s1, s2) that share one clock. It serves as the shared buffer between the
// Nios II data master and a DMA/streaming master.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   word-address width of both ports
//   DEPTH        number of implemented words (<= 2**ADDR_WIDTH)
//   READ_LATENCY 1 = RAM output register only, 2 = extra output register
//   INIT_FILE    power-up contents, handed to the FPGA tool via attribute
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   reset_req, clken        stall controls: en = clken & ~reset_req
//   sN_address/chipselect/read/write/byteenable/writedata   request, N = 1, 2
//   sN_readdata, sN_readdatavalid                          read response
//   oor_error               sticky out-of-range access flag
// -----------------------------------------------------------------------------
module avalon_onchip_memory_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 15,
    parameter int    DEPTH        = 24500,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_memory_dp.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    oor_error
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("avalon_onchip_memory_dp: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("avalon_onchip_memory_dp: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("avalon_onchip_memory_dp: DEPTH exceeds the address space");
    end

    // Storage; the attribute lets the FPGA flow preload it from INIT_FILE.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports folded into index 0 (s1) and index 1 (s2).
    logic [ADDR_WIDTH-1:0] addr_s  [2];
    logic [NUM_BYTES-1:0]  be_s    [2];
    logic [DATA_WIDTH-1:0] wdata_s [2];
    logic [1:0]            cs_s;
    logic [1:0]            rd_s;
    logic [1:0]            wr_s;

    assign addr_s[0]  = s1_address;
    assign addr_s[1]  = s2_address;
    assign be_s[0]    = s1_byteenable;
    assign be_s[1]    = s2_byteenable;
    assign wdata_s[0] = s1_writedata;
    assign wdata_s[1] = s2_writedata;
    assign cs_s       = {s2_chipselect, s1_chipselect};
    assign rd_s       = {s2_read, s1_read};
    assign wr_s       = {s2_write, s1_write};

    logic                  en_s;
    logic [1:0]            in_range_s;
    logic [1:0]            wr_acc_s;
    logic [1:0]            rd_acc_s;
    logic [1:0]            mem_we_s;
    logic                  oor_hit_s;
    logic [DATA_WIDTH-1:0] rd_word_s [2];
    logic [1:0]            src_v_s;
    logic [DATA_WIDTH-1:0] src_d_s   [2];

    // Pipeline state: stage_* is the extra register used only at latency 2.
    logic [1:0]            stage_v_q, stage_v_d;
    logic [DATA_WIDTH-1:0] stage_d_q [2];
    logic [DATA_WIDTH-1:0] stage_d_d [2];
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q   [2];
    logic [DATA_WIDTH-1:0] rdata_d   [2];
    logic                  oor_q, oor_d;

    // Request decode: acceptance, range check and array read per port.
    always_comb begin
        en_s      = clken & ~reset_req;
        oor_hit_s = 1'b0;
        for (int p = 0; p < 2; p++) begin
            in_range_s[p] = ({1'b0, addr_s[p]} < DEPTH_LIMIT);
            wr_acc_s[p]   = cs_s[p] & wr_s[p] & en_s;
            // A simultaneous write strobe suppresses the read.
            rd_acc_s[p]   = cs_s[p] & rd_s[p] & ~wr_s[p] & en_s;
            mem_we_s[p]   = wr_acc_s[p] & in_range_s[p] & ~reset;
            if ((wr_acc_s[p] | rd_acc_s[p]) & ~in_range_s[p]) begin
                oor_hit_s = 1'b1;
            end else begin
                oor_hit_s = oor_hit_s;
            end
            // Out-of-range reads return zero instead of touching the array.
            if (rd_acc_s[p] & in_range_s[p]) begin
                rd_word_s[p] = mem[addr_s[p]];
            end else begin
                rd_word_s[p] = '0;
            end
        end
    end

    // Next-state of the read pipelines and error flag; everything holds when en=0.
    always_comb begin
        oor_d = oor_q | (en_s & oor_hit_s);
        for (int p = 0; p < 2; p++) begin
            src_v_s[p] = (READ_LATENCY == 2) ? stage_v_q[p] : rd_acc_s[p];
            src_d_s[p] = (READ_LATENCY == 2) ? stage_d_q[p] : rd_word_s[p];
            if (en_s) begin
                stage_v_d[p] = rd_acc_s[p];
                stage_d_d[p] = rd_word_s[p];
                rvalid_d[p]  = src_v_s[p];
                // readdata only changes when a new valid word arrives.
                rdata_d[p]   = src_v_s[p] ? src_d_s[p] : rdata_q[p];
            end else begin
                stage_v_d[p] = stage_v_q[p];
                stage_d_d[p] = stage_d_q[p];
                rvalid_d[p]  = rvalid_q[p];
                rdata_d[p]   = rdata_q[p];
            end
        end
    end

    // Pipeline and flag registers; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_v_q <= 2'b00;
            rvalid_q  <= 2'b00;
            oor_q     <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                stage_d_q[p] <= '0;
                rdata_q[p]   <= '0;
            end
        end else begin
            stage_v_q <= stage_v_d;
            rvalid_q  <= rvalid_d;
            oor_q     <= oor_d;
            for (int p = 0; p < 2; p++) begin
                stage_d_q[p] <= stage_d_d[p];
                rdata_q[p]   <= rdata_d[p];
            end
        end
    end

    // Array writes. s2 is applied first so that s1 overrides it on any byte
    // lane both ports enable at the same address; lanes enabled by only one
    // port keep that port's byte. Reads see the pre-write contents.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (mem_we_s[p] && be_s[p][b]) begin
                    mem[addr_s[p]][b*8 +: 8] <= wdata_s[p][b*8 +: 8];
                end
            end
        end
    end

    assign s1_readdata      = rdata_q[0];
    assign s2_readdata      = rdata_q[1];
    assign s1_readdatavalid = rvalid_q[0];
    assign s2_readdatavalid = rvalid_q[1];
    assign oor_error        = oor_q;

endmodule
